// File: rtl/fp_unpack_norm_pkg.sv
// Shared constants and types for the FPU operand unpacker (package fpu_pkg).
package fpu_pkg;

    localparam int SIG_W    = 53;
    localparam int EXP_W    = 11;
    localparam int LZ_W     = 6;
    localparam int DBL_BIAS = 1023;
    localparam int SGL_BIAS = 127;
    localparam int BIAS_ADJ = DBL_BIAS - SGL_BIAS;
    localparam int EMIN_D   = 1;
    localparam int EMIN_S   = BIAS_ADJ + 1;

    typedef struct packed {
        logic zero;
        logic subn;
        logic inf;
        logic qnan;
        logic snan;
    } fp_class_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
        logic [LZ_W-1:0]  lz;
        fp_class_t        cls;
    } unpacked_t;

    function automatic logic [EXP_W-1:0] emin_of(input logic is_dbl);
        if (is_dbl) begin
            return EXP_W'(EMIN_D);
        end else begin
            return EXP_W'(EMIN_S);
        end
    endfunction

endpackage

// File: rtl/fp_unpack_norm_lzc53.sv
// Combinational 53-bit leading-zero counter; an all-zero input yields 53.
module lzc53 (
    input  logic [52:0] sig_i,
    output logic [5:0]  cnt_o
);

    // Scan upward from the LSB so the most significant set bit is the last writer.
    always_comb begin
        cnt_o = 6'd53;
        for (int i = 0; i < 53; i++) begin
            if (sig_i[i]) begin
                cnt_o = 6'(52 - i);
            end else begin
                cnt_o = cnt_o;
            end
        end
    end

endmodule

// File: rtl/fp_unpack_norm.sv
// Two-stage FPU operand unpacker / subnormal pre-normalizer with valid/ready flow control.
// Optional FPU_UNPACK_DAZ_EN: subnormal inputs are flushed to signed zero.
module fp_unpack_norm #(
    parameter int SIG_W = fpu_pkg::SIG_W,
    parameter int EXP_W = fpu_pkg::EXP_W,
    parameter int LZ_W  = fpu_pkg::LZ_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      fa,
    input  logic             db,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sa,
    output logic [EXP_W-1:0] ea,
    output logic [SIG_W-1:0] fn,
    output logic [LZ_W-1:0]  lz,
    output logic             zero,
    output logic             subn,
    output logic             inf,
    output logic             qnan,
    output logic             snan
);

    import fpu_pkg::*;

    logic [10:0] exp_raw_s;
    logic [51:0] frac_s;
    logic        exp_zero_s;
    logic        exp_max_s;
    logic        frac_zero_s;
    logic        is_zero_s;
    logic        is_subn_s;
    logic [52:0] raw_sig_s;
    logic [5:0]  lzc_s;
    unpacked_t   dec_s;
    unpacked_t   s1_q;
    unpacked_t   s2_d;
    unpacked_t   s2_q;
    logic        s1_valid_q;
    logic        s2_valid_q;
    logic        s2_load_s;
    logic        in_fire_s;

    // Field extraction; single-precision fraction is left-aligned into the double slot.
    always_comb begin
        if (db) begin
            exp_raw_s = fa[62:52];
            frac_s    = fa[51:0];
            exp_max_s = (fa[62:52] == 11'h7FF);
        end else begin
            exp_raw_s = {3'b000, fa[62:55]};
            frac_s    = {fa[54:32], 29'd0};
            exp_max_s = (fa[62:55] == 8'hFF);
        end
        exp_zero_s  = (exp_raw_s == 11'd0);
        frac_zero_s = (frac_s == 52'd0);
`ifdef FPU_UNPACK_DAZ_EN
        is_zero_s = exp_zero_s;
        is_subn_s = 1'b0;
        raw_sig_s = exp_zero_s ? 53'd0 : {1'b1, frac_s};
`else
        is_zero_s = exp_zero_s && frac_zero_s;
        is_subn_s = exp_zero_s && !frac_zero_s;
        raw_sig_s = {!exp_zero_s, frac_s};
`endif
    end

    lzc53 u_lzc (
        .sig_i (raw_sig_s),
        .cnt_o (lzc_s)
    );

    // Stage-1 payload; single inf/NaN map onto the double all-ones exponent.
    always_comb begin
        dec_s          = '0;
        dec_s.sign     = fa[63];
        dec_s.sig      = raw_sig_s;
        dec_s.cls.zero = is_zero_s;
        dec_s.cls.subn = is_subn_s;
        dec_s.cls.inf  = exp_max_s && frac_zero_s;
        dec_s.cls.qnan = exp_max_s && frac_s[51];
        dec_s.cls.snan = exp_max_s && !frac_zero_s && !frac_s[51];
        if (is_zero_s) begin
            dec_s.lz = 6'd0;
        end else begin
            dec_s.lz = lzc_s;
        end
        if (exp_zero_s) begin
            dec_s.exp = emin_of(db);
        end else if (exp_max_s) begin
            dec_s.exp = 11'h7FF;
        end else if (db) begin
            dec_s.exp = exp_raw_s;
        end else begin
            dec_s.exp = exp_raw_s + 11'(BIAS_ADJ);
        end
    end

    // Stage-2 payload: left-align the significand; exponent is left for downstream.
    always_comb begin
        s2_d     = s1_q;
        s2_d.sig = s1_q.sig << s1_q.lz;
    end

    assign s2_load_s = !s2_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_load_s;
    assign in_fire_s = in_valid && in_ready;

    // Stage-1 register: captures on accept, empties when stage 2 takes its content.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (in_fire_s) begin
            s1_valid_q <= 1'b1;
            s1_q       <= dec_s;
        end else if (s2_load_s) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_q;
        end
    end

    // Stage-2 output register: holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else if (s2_load_s) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_q <= s2_d;
            end else begin
                s2_q <= s2_q;
            end
        end else begin
            s2_valid_q <= s2_valid_q;
        end
    end

    assign out_valid = s2_valid_q;
    assign sa        = s2_q.sign;
    assign ea        = s2_q.exp;
    assign fn        = s2_q.sig;
    assign lz        = s2_q.lz;
    assign zero      = s2_q.cls.zero;
    assign subn      = s2_q.cls.subn;
    assign inf       = s2_q.cls.inf;
    assign qnan      = s2_q.cls.qnan;
    assign snan      = s2_q.cls.snan;

endmodule
